hm2_adc_ltc2308_scan: RTL

Autonomous scan sequencer for the LTC2308 8-channel 12-bit SPI ADC fitted to the DE1-SoC board. It runs in the hostmot2 low-speed clock domain (50 MHz ClockLow). It cycles CONVST/SCK/SDI/SDO frames over the channels enabled in a mask, and emits one tagged 12-bit result per frame to the downstream hostmot2 register file. It is the board-specific consumer of the board ADC selection and drives the physical ADC pins directly.

---
 rtl/hm2_adc_ltc2308_scan.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hm2_adc_ltc2308_scan.sv
// LTC2308 scan sequencer: walks the enabled channels, drives CONVST/SCK/SDI
// and emits one tagged 12-bit result per frame (config is one frame ahead).
module hm2_adc_ltc2308_scan #(
   parameter int CLK_HZ      = 50000000,
   parameter int SCK_DIV     = 2,
   parameter int CONV_CYCLES = 80,
   parameter int ACQ_CYCLES  = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  ch_mask,
   input  logic        unipolar,
   output logic        adc_convst,
   output logic        adc_sck,
   output logic        adc_sdi,
   input  logic        adc_sdo,
   output logic        res_valid,
   output logic [2:0]  res_ch,
   output logic [11:0] res_data,
   output logic        busy
);

   if (CLK_HZ < 1 || SCK_DIV < 1 ||
       CONV_CYCLES < 3 || ACQ_CYCLES < 1) begin : g_param_err
      $error("hm2_adc_ltc2308_scan: bad parameters");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_SHIFT,
      S_ACQ
   } state_t;

   localparam int CMAX = (CONV_CYCLES > ACQ_CYCLES) ?
                         CONV_CYCLES : ACQ_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

   localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
   localparam logic [CW-1:0] ACQ_LAST  = CW'(ACQ_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(SCK_DIV - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_div;
   logic          r_hi;
   logic [3:0]    r_bit;
   logic [2:0]    r_ch;
   logic [2:0]    r_cur_ch;
   logic [2:0]    r_prv_ch;
   logic [5:0]    r_cfg;
   logic          r_prime;
   logic          r_adv_ok;
   logic [11:0]   r_shift;
   logic          r_convst;
   logic          r_sck;
   logic          r_sdi;
   logic          r_busy;
   logic          r_res_valid;
   logic [2:0]    r_res_ch;
   logic [11:0]   r_res_data;

   state_t        w_state;
   logic [CW-1:0] w_cnt;
   logic [DW-1:0] w_div;
   logic          w_hi;
   logic [3:0]    w_bit;
   logic          w_enter;
   logic [2:0]    w_first;
   logic [2:0]    w_nxt_ch;
   logic          w_found;
   logic          w_acq_first;
   logic [2:0]    w_ch_go;
   logic          w_go_ok;
   logic [5:0]    w_cfg_go;
   logic [5:0]    w_cfg_nxt;
   logic [7:0]    w_cfg8;
   logic [2:0]    w_sdi_idx;
   logic          w_convst_n;
   logic          w_sck_n;
   logic          w_sdi_n;
   logic          w_sample;

   always_comb begin
      w_first = '0;
      for (int i = 7; i >= 0; i--) begin
         if (ch_mask[i]) w_first = 3'(i);
      end
   end

   // Next set bit strictly above r_ch (wrapping), else r_ch itself.
   always_comb begin
      w_nxt_ch = r_ch;
      w_found  = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         if (ch_mask[r_ch + 3'(i)]) begin
            w_nxt_ch = r_ch + 3'(i);
            w_found  = 1'b1;
         end
      end
      if (!w_found && ch_mask[r_ch]) w_found = 1'b1;
   end

   always_comb begin
      w_acq_first = (r_state == S_ACQ) && (r_cnt == '0);
      if (r_state == S_IDLE) w_ch_go = w_first;
      else if (w_acq_first)  w_ch_go = w_nxt_ch;
      else                   w_ch_go = r_ch;
      w_go_ok  = w_acq_first ? w_found : r_adv_ok;
      w_cfg_go = {1'b1, w_ch_go[0], w_ch_go[2],
                  w_ch_go[1], unipolar, 1'b0};
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_div   = r_div;
      w_hi    = r_hi;
      w_bit   = r_bit;
      w_enter = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (enable && (ch_mask != 8'h00)) begin
               w_state = S_CONV;
               w_cnt   = '0;
               w_enter = 1'b1;
            end
         end
         S_CONV: begin
            if (r_cnt == CONV_LAST) begin
               w_state = S_SHIFT;
               w_div   = '0;
               w_hi    = 1'b0;
               w_bit   = '0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_SHIFT: begin
            if (r_div == DIV_LAST) begin
               w_div = '0;
               if (!r_hi) begin
                  w_hi = 1'b1;
               end else if (r_bit == 4'd11) begin
                  w_state = S_ACQ;
                  w_cnt   = '0;
                  w_hi    = 1'b0;
               end else begin
                  w_hi  = 1'b0;
                  w_bit = r_bit + 4'd1;
               end
            end else begin
               w_div = r_div + DW'(1);
            end
         end
         S_ACQ: begin
            if (r_cnt == ACQ_LAST) begin
               if (enable && (ch_mask != 8'h00) && w_go_ok) begin
                  w_state = S_CONV;
                  w_cnt   = '0;
                  w_enter = 1'b1;
               end else begin
                  w_state = S_IDLE;
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   // Pin outputs are decoded from the next state so they line up with it.
   always_comb begin
      w_cfg_nxt  = w_enter ? w_cfg_go : r_cfg;
      w_cfg8     = {w_cfg_nxt, 2'b00};
      w_sdi_idx  = 3'd7 - w_bit[2:0];
      w_convst_n = (w_state == S_CONV) && (w_cnt < CW'(2));
      w_sck_n    = (w_state == S_SHIFT) && w_hi;
      w_sdi_n    = (w_state == S_SHIFT) && (w_bit < 4'd6) &&
                   w_cfg8[w_sdi_idx];
      w_sample   = (r_state == S_SHIFT) && !r_hi &&
                   (r_div == DIV_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_div       <= '0;
         r_hi        <= 1'b0;
         r_bit       <= '0;
         r_ch        <= '0;
         r_cur_ch    <= '0;
         r_prv_ch    <= '0;
         r_cfg       <= '0;
         r_prime     <= 1'b1;
         r_adv_ok    <= 1'b0;
         r_shift     <= '0;
         r_convst    <= 1'b0;
         r_sck       <= 1'b0;
         r_sdi       <= 1'b0;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_ch    <= '0;
         r_res_data  <= '0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_div       <= w_div;
         r_hi        <= w_hi;
         r_bit       <= w_bit;
         r_cfg       <= w_cfg_nxt;
         r_convst    <= w_convst_n;
         r_sck       <= w_sck_n;
         r_sdi       <= w_sdi_n;
         r_busy      <= (w_state != S_IDLE);
         r_res_valid <= 1'b0;
         if (w_sample) r_shift <= {r_shift[10:0], adc_sdo};
         if (w_acq_first) begin
            if (!r_prime) begin
               r_res_valid <= 1'b1;
               r_res_data  <= r_shift;
               r_res_ch    <= r_prv_ch;
            end
            r_prime  <= 1'b0;
            r_ch     <= w_nxt_ch;
            r_adv_ok <= w_found;
         end
         if (w_enter) begin
            r_ch     <= w_ch_go;
            r_cur_ch <= w_ch_go;
            r_prv_ch <= r_cur_ch;
            if (r_state == S_IDLE) r_prime <= 1'b1;
         end
      end
   end

   assign adc_convst = r_convst;
   assign adc_sck    = r_sck;
   assign adc_sdi    = r_sdi;
   assign res_valid  = r_res_valid;
   assign res_ch     = r_res_ch;
   assign res_data   = r_res_data;
   assign busy       = r_busy;

endmodule
